// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: mem_ctrl bit
// positions, access size encodings and the data-memory handshake states.
package mem_stage_pkg;

    localparam int CTRL_LOAD  = 4;
    localparam int CTRL_STORE = 3;
    localparam int CTRL_UNS   = 2;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for data-memory accesses: byte enables, store
// replication, load extraction/extension and misalignment detection.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] st_din,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8    = ld_word[7:0];
        lane16   = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        be       = 4'b1111;
        st_data  = st_din;
        ld_data  = ld_word;
        misalign = 1'b0;

        unique case (addr_lo)
            2'd0:    lane8 = ld_word[7:0];
            2'd1:    lane8 = ld_word[15:8];
            2'd2:    lane8 = ld_word[23:16];
            default: lane8 = ld_word[31:24];
        endcase

        // Size 2'b11 is not a legal encoding; it behaves as a word access.
        unique case (size)
            MEM_BYTE: begin
                be      = 4'b0001 << addr_lo;
                st_data = {4{st_din[7:0]}};
                ld_data = uns ? {24'b0, lane8} : {{24{lane8[7]}}, lane8};
            end
            MEM_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{st_din[15:0]}};
                ld_data  = uns ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
                misalign = addr_lo[0];
            end
            default: begin
                be       = 4'b1111;
                st_data  = st_din;
                ld_data  = ld_word;
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, single-outstanding dmem
// req/ack FSM with timeout, MEM/WB register. MEM_MISALIGN_TRAP_EN traps misaligned accesses.
//
// state | meaning
// IDLE  | no access pending; zero-wait accesses complete here
// WAIT  | request outstanding, counting wait cycles toward timeout
// DONE  | one-cycle drain of an aborted access, request dropped
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_alu_res,
    input  logic [31:0] EX_mem_din,
    input  logic        EX_vld,
    input  logic        EX_alu_busy,
    input  logic [4:0]  EX_mem_ctrl,
    input  logic [4:0]  EX_rd,
    input  logic        EX_rd_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_data,
    output logic        MEM_busy,
    output logic [31:0] MEM_WB_data,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_we,
    output logic        MEM_WB_vld,
    output logic        MEM_WB_err
);

    localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMEM_TIMEOUT);

    logic [31:0]    ex_alu_res;
    logic [31:0]    ex_din;
    logic           ex_vld;
    logic [4:0]     ex_ctrl;
    logic [4:0]     ex_rd;
    logic           ex_rd_we;

    mem_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [3:0]     be;
    logic [31:0]    st_data;
    logic [31:0]    ld_data;
    logic           misalign;
    logic           trap;
    logic           mem_op;
    logic           is_store;
    logic           is_load;
    logic           abort;

    mem_align u_align (
        .addr_lo  (ex_alu_res[1:0]),
        .size     (ex_ctrl[1:0]),
        .uns      (ex_ctrl[CTRL_UNS]),
        .st_din   (ex_din),
        .ld_word  (dmem_rdata),
        .be       (be),
        .st_data  (st_data),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    // Store wins when both load and store bits are set.
    assign is_store = ex_ctrl[CTRL_STORE];
    assign is_load  = ex_ctrl[CTRL_LOAD] & ~is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = ex_vld & (is_load | is_store) & misalign;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign trap = 1'b0;
`endif

    assign mem_op     = ex_vld & (is_load | is_store) & ~trap;
    assign abort      = (state == DONE);
    assign dmem_req   = mem_op & ~abort;
    assign MEM_busy   = mem_op & ~dmem_ack & ~abort;
    assign dmem_we    = dmem_req & is_store;
    assign dmem_be    = dmem_we ? be : 4'b0000;
    assign dmem_addr  = {ex_alu_res[31:2], 2'b00};
    assign dmem_wdata = st_data;
    assign MEM_data   = ex_alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_alu_res <= '0;
            ex_din     <= '0;
            ex_vld     <= 1'b0;
            ex_ctrl    <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
        end else if (!MEM_busy) begin
            ex_alu_res <= EX_alu_res;
            ex_din     <= EX_mem_din;
            ex_vld     <= EX_vld & ~EX_alu_busy;
            ex_ctrl    <= EX_mem_ctrl;
            ex_rd      <= EX_rd;
            ex_rd_we   <= EX_rd_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (mem_op && !dmem_ack) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (!mem_op || dmem_ack) begin
                    state_nxt = IDLE;
                end else begin
                    if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_MAX) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A stalled cycle leaves a bubble in MEM/WB; data and rd keep their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_WB_data <= '0;
            MEM_WB_rd   <= '0;
            MEM_WB_we   <= 1'b0;
            MEM_WB_vld  <= 1'b0;
            MEM_WB_err  <= 1'b0;
        end else if (MEM_busy) begin
            MEM_WB_we   <= 1'b0;
            MEM_WB_vld  <= 1'b0;
            MEM_WB_err  <= 1'b0;
        end else begin
            MEM_WB_data <= is_load ? ld_data : ex_alu_res;
            MEM_WB_rd   <= ex_rd;
            MEM_WB_we   <= ex_rd_we & ex_vld & ~abort & ~trap;
            MEM_WB_vld  <= ex_vld;
            MEM_WB_err  <= ex_vld & (abort | trap);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of zero-wait vectors plus hand
// sequences for waits, timeout, misalignment, reset and upstream stall.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] EX_alu_res;
    logic [31:0] EX_mem_din;
    logic        EX_vld;
    logic        EX_alu_busy;
    logic [4:0]  EX_mem_ctrl;
    logic [4:0]  EX_rd;
    logic        EX_rd_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] MEM_data;
    logic        MEM_busy;
    logic [31:0] MEM_WB_data;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_we;
    logic        MEM_WB_vld;
    logic        MEM_WB_err;

    int errors = 0;
    int checks = 0;

    mem_stage #(.DMEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .EX_alu_res  (EX_alu_res),
        .EX_mem_din  (EX_mem_din),
        .EX_vld      (EX_vld),
        .EX_alu_busy (EX_alu_busy),
        .EX_mem_ctrl (EX_mem_ctrl),
        .EX_rd       (EX_rd),
        .EX_rd_we    (EX_rd_we),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .MEM_data    (MEM_data),
        .MEM_busy    (MEM_busy),
        .MEM_WB_data (MEM_WB_data),
        .MEM_WB_rd   (MEM_WB_rd),
        .MEM_WB_we   (MEM_WB_we),
        .MEM_WB_vld  (MEM_WB_vld),
        .MEM_WB_err  (MEM_WB_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] din, input logic [4:0] ctrl,
                         input logic [4:0] rd, input logic rd_we);
        EX_alu_res  = alu;
        EX_mem_din  = din;
        EX_mem_ctrl = ctrl;
        EX_rd       = rd;
        EX_rd_we    = rd_we;
        EX_vld      = 1'b1;
        EX_alu_busy = 1'b0;
    endtask

    typedef struct {
        logic [31:0] alu;
        logic [31:0] din;
        logic [4:0]  ctrl;
        logic        rd_we;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        logic        exp_wb_we;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        vecs[0]  = '{32'h0000_1234, 32'h0, 5'b00000, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,     4'b0000, 32'h0,         32'h0000_1234, 1'b1};
        vecs[1]  = '{32'h0000_0103, 32'h0, 5'b10000, 1'b1, 32'h80AA_BBCC, 1'b1, 1'b0, 32'h100,   4'b0000, 32'h0,         32'hFFFF_FF80, 1'b1};
        vecs[2]  = '{32'h0000_0102, 32'h0, 5'b10101, 1'b1, 32'h8001_0000, 1'b1, 1'b0, 32'h100,   4'b0000, 32'h0,         32'h0000_8001, 1'b1};
        vecs[3]  = '{32'h0000_0200, 32'h0, 5'b10010, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h200,   4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[4]  = '{32'h0000_0206, 32'h1234_ABCD, 5'b01001, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204,   4'b1100, 32'hABCD_ABCD, 32'h0000_0206, 1'b0};
        vecs[5]  = '{32'h0000_0300, 32'hCAFE_F00D, 5'b01010, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300,   4'b1111, 32'hCAFE_F00D, 32'h0000_0300, 1'b0};
        vecs[6]  = '{32'h0000_0100, 32'h0, 5'b10001, 1'b1, 32'h1234_F00F, 1'b1, 1'b0, 32'h100,   4'b0000, 32'h0,         32'hFFFF_F00F, 1'b1};
        vecs[7]  = '{32'h0000_0101, 32'h0, 5'b10100, 1'b1, 32'h0000_A500, 1'b1, 1'b0, 32'h100,   4'b0000, 32'h0,         32'h0000_00A5, 1'b1};
        vecs[8]  = '{32'h0000_0010, 32'h1122_3344, 5'b11010, 1'b1, 32'h0, 1'b1, 1'b1, 32'h10,    4'b1111, 32'h1122_3344, 32'h0000_0010, 1'b1};
        vecs[9]  = '{32'h0000_0002, 32'h0000_007F, 5'b01000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,     4'b0100, 32'h7F7F_7F7F, 32'h0000_0002, 1'b0};
        vecs[10] = '{32'h0000_0402, 32'h0, 5'b10000, 1'b1, 32'h0071_0000, 1'b1, 1'b0, 32'h400,   4'b0000, 32'h0,         32'h0000_0071, 1'b1};

        rst = 1'b0;
        EX_alu_res = '0; EX_mem_din = '0; EX_vld = 1'b0; EX_alu_busy = 1'b0;
        EX_mem_ctrl = '0; EX_rd = '0; EX_rd_we = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        #12;
        chk("rst_req",    {31'b0, dmem_req},   32'h0);
        chk("rst_busy",   {31'b0, MEM_busy},   32'h0);
        chk("rst_addr",   dmem_addr,           32'h0);
        chk("rst_wdata",  dmem_wdata,          32'h0);
        chk("rst_be",     {28'b0, dmem_be},    32'h0);
        chk("rst_memdat", MEM_data,            32'h0);
        chk("rst_wb",     {MEM_WB_data[26:0], MEM_WB_rd} | {27'b0, MEM_WB_we, MEM_WB_vld, MEM_WB_err, 2'b0}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero-wait table
        foreach (vecs[i]) begin
            drive(vecs[i].alu, vecs[i].din, vecs[i].ctrl, 5'(i + 1), vecs[i].rd_we);
            @(posedge clk); #1;
            EX_vld = 1'b0;
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].exp_req});
            chk($sformatf("v%0d_we", i),  {31'b0, dmem_we},  {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_be", i),  {28'b0, dmem_be},  {28'b0, vecs[i].exp_be});
            chk($sformatf("v%0d_memdata", i), MEM_data, vecs[i].alu);
            if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_we)  chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
            dmem_ack   = vecs[i].exp_req;
            dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_busy", i), {31'b0, MEM_busy}, 32'h0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            chk($sformatf("v%0d_wbdata", i), MEM_WB_data, vecs[i].exp_wb);
            chk($sformatf("v%0d_wbwe", i),   {31'b0, MEM_WB_we},  {31'b0, vecs[i].exp_wb_we});
            chk($sformatf("v%0d_wbvld", i),  {31'b0, MEM_WB_vld}, 32'h1);
            chk($sformatf("v%0d_wberr", i),  {31'b0, MEM_WB_err}, 32'h0);
            chk($sformatf("v%0d_wbrd", i),   {27'b0, MEM_WB_rd},  32'(i + 1));
        end

        // Byte store acked after three stalled cycles; the following add is held.
        drive(32'h0000_0201, 32'h0000_0055, 5'b01000, 5'd2, 1'b0);
        @(posedge clk); #1;
        drive(32'h0000_0099, 32'h0, 5'b00000, 5'd7, 1'b1);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (MEM_busy) n++;
            chk("wst_req",   {31'b0, dmem_req}, 32'h1);
            chk("wst_addr",  dmem_addr,         32'h200);
            chk("wst_be",    {28'b0, dmem_be},  32'h2);
            chk("wst_wdata", dmem_wdata,        32'h5555_5555);
            @(posedge clk); #1;
            chk("wst_bubble", {31'b0, MEM_WB_vld}, 32'h0);
        end
        chk("wst_stall_cycles", 32'(n), 32'd3);
        dmem_ack = 1'b1;
        #1;
        chk("wst_ack_busy", {31'b0, MEM_busy}, 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("wst_wbvld",  {31'b0, MEM_WB_vld}, 32'h1);
        chk("wst_wbdata", MEM_WB_data,         32'h0000_0201);
        chk("wst_wbwe",   {31'b0, MEM_WB_we},  32'h0);
        chk("wst_next",   MEM_data,            32'h0000_0099);
        EX_vld = 1'b0;
        @(posedge clk); #1;
        chk("wst_next_wb",   MEM_WB_data,        32'h0000_0099);
        chk("wst_next_rd",   {27'b0, MEM_WB_rd}, 32'd7);
        chk("wst_next_we",   {31'b0, MEM_WB_we}, 32'h1);

        // Timeout: no ack at all.
        drive(32'h0000_0400, 32'h0, 5'b10010, 5'd3, 1'b1);
        @(posedge clk); #1;
        drive(32'h0000_0077, 32'h0, 5'b00000, 5'd8, 1'b1);
        n = 0;
        while (MEM_busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("to_stall_cycles", 32'(n), 32'd16);
        chk("to_done_req",  {31'b0, dmem_req}, 32'h0);
        chk("to_done_busy", {31'b0, MEM_busy}, 32'h0);
        @(posedge clk); #1;
        chk("to_err",   {31'b0, MEM_WB_err}, 32'h1);
        chk("to_we",    {31'b0, MEM_WB_we},  32'h0);
        chk("to_rd",    {27'b0, MEM_WB_rd},  32'd3);
        chk("to_next",  MEM_data,            32'h0000_0077);
        EX_vld = 1'b0;
        @(posedge clk); #1;
        chk("to_next_wb",  MEM_WB_data,         32'h0000_0077);
        chk("to_next_we",  {31'b0, MEM_WB_we},  32'h1);
        chk("to_next_err", {31'b0, MEM_WB_err}, 32'h0);

        // Word load at a misaligned address.
        drive(32'h0000_0102, 32'h0, 5'b10010, 5'd4, 1'b1);
        @(posedge clk); #1;
        EX_vld = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req",  {31'b0, dmem_req}, 32'h0);
        chk("mis_busy", {31'b0, MEM_busy}, 32'h0);
        @(posedge clk); #1;
        chk("mis_err",  {31'b0, MEM_WB_err}, 32'h1);
        chk("mis_we",   {31'b0, MEM_WB_we},  32'h0);
`else
        chk("mis_req",  {31'b0, dmem_req}, 32'h1);
        chk("mis_addr", dmem_addr,         32'h100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1122_3344;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("mis_data", MEM_WB_data,         32'h1122_3344);
        chk("mis_err",  {31'b0, MEM_WB_err}, 32'h0);
        chk("mis_we",   {31'b0, MEM_WB_we},  32'h1);
`endif

        // EX result arriving while the divider is busy becomes a bubble.
        drive(32'h0000_00AB, 32'h0, 5'b00000, 5'd6, 1'b1);
        EX_alu_busy = 1'b1;
        @(posedge clk); #1;
        EX_alu_busy = 1'b0;
        EX_vld = 1'b0;
        chk("ab_memdata", MEM_data, 32'h0000_00AB);
        @(posedge clk); #1;
        chk("ab_vld", {31'b0, MEM_WB_vld}, 32'h0);
        chk("ab_we",  {31'b0, MEM_WB_we},  32'h0);

        // Reset asserted mid-wait.
        drive(32'h0000_0500, 32'h0, 5'b10010, 5'd5, 1'b1);
        @(posedge clk); #1;
        EX_vld = 1'b0;
        @(posedge clk); #1;
        chk("rw_busy_before", {31'b0, MEM_busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rw_req",     {31'b0, dmem_req},   32'h0);
        chk("rw_busy",    {31'b0, MEM_busy},   32'h0);
        chk("rw_memdata", MEM_data,            32'h0);
        #1;
        rst = 1'b1;
        drive(32'h0000_0042, 32'h0, 5'b00000, 5'd9, 1'b1);
        @(posedge clk); #1;
        EX_vld = 1'b0;
        chk("rw_after_busy", {31'b0, MEM_busy}, 32'h0);
        @(posedge clk); #1;
        chk("rw_after_wb", MEM_WB_data,        32'h0000_0042);
        chk("rw_after_we", {31'b0, MEM_WB_we}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between `ex_stage` and writeback. Registers the EX results into the EX/MEM pipeline register, runs a single-outstanding req/ack transaction with the data memory for loads and stores, and aligns, extends and registers the result into the MEM/WB register. Exposes the in-flight ALU result as the `MEM_data` forwarding source. Stalls the upstream pipeline while a data-memory access is pending.

## Interface
- `DMEM_TIMEOUT`, default 15: maximum number of wait cycles after the request cycle before the access is aborted.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `EX_alu_res` in 32: ALU result and effective address.
- `EX_mem_din` in 32: store data.
- `EX_vld` in 1: the EX result is valid.
- `EX_alu_busy` in 1: divider busy; while high, EX is not captured and a bubble is inserted.
- `EX_mem_ctrl` in 5: bit [4] load, bit [3] store, bit [2] unsigned load, bits [1:0] size (00 byte, 01 half, 10 word).
- `EX_rd` in 5: destination register.
- `EX_rd_we` in 1: destination write enable.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word address, with bits [1:0] forced to 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: access complete; read data is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `MEM_data` out 32: the EX/MEM ALU result, used for forwarding. This path is combinational from the register.
- `MEM_busy` out 1: stall request to the IF, ID and EX stages. This output is combinational.
- `MEM_WB_data` out 32: registered writeback value.
- `MEM_WB_rd` out 5: registered destination register.
- `MEM_WB_we` out 1: registered write enable.
- `MEM_WB_vld` out 1: registered valid.
- `MEM_WB_err` out 1: registered bus-error flag.

## Operation
- **EX/MEM capture.** When `MEM_busy`=0, every edge loads the `EX_*` inputs into the EX/MEM register. The captured valid is `EX_vld & ~EX_alu_busy`. When `MEM_busy`=1, the register holds.
- **Memory-op definition.** An access is a memory op when it is valid and `mem_ctrl[4]|mem_ctrl[3]` is set. If both bits [4] and [3] are set, the access is treated as a store.
- **Request.** `dmem_req` = (memory op) & (state != DONE).
  - `dmem_addr`, `dmem_be` and `dmem_wdata` are derived from the EX/MEM register.
  - These outputs are stable while `dmem_req` is held.
- **Byte enables.**
  - Byte: `be = 0001 << addr[1:0]`.
  - Half: `be = 0011 << {addr[1],0}`.
  - Word: `be = 1111`.
- **Store data replication.** Byte stores replicate `din[7:0]` ×4. Half stores replicate `din[15:0]` ×2.
- **Load data extraction.** Select the lane using `addr[1:0]`, then sign-extend, or zero-extend when bit [2] is set.
- **State machine.** States IDLE, WAIT, DONE.
  - IDLE: on a memory op with `ack`=0, go to WAIT and clear the counter. With `ack`=1, the access completes in the same cycle and the state stays IDLE.
  - WAIT: increment the counter each cycle. On `ack`, complete and go to IDLE. If the counter reaches `DMEM_TIMEOUT` without `ack`, abort and go to DONE.
  - DONE: lasts exactly one cycle with `dmem_req`=0. It drains the aborted instruction and returns to IDLE.
- **Stall.** `MEM_busy` = (memory op) & ~`dmem_ack` & (state != DONE).
- **Writeback register.** It loads whenever `MEM_busy`=0.
  - `data` = the extracted load data for loads, otherwise the ALU result.
  - `we` = `rd_we` & `vld` & ~abort.
  - `err` = abort.
  - A held (stalled) cycle writes a bubble into MEM/WB, i.e. `vld`=0 and `we`=0.

## Timing
- **Reset.** All outputs are 0, the state is IDLE, the counter is 0, and the EX/MEM register is cleared with `vld`=0. Reset asserted mid-access drops `dmem_req` immediately. The outstanding transaction is abandoned.
- **Non-memory ops.** Latency is 1 cycle from EX/MEM to MEM/WB.
- **Zero-wait memory ops.** Same latency as non-memory ops.
- **Waited memory ops.** Each wait cycle adds one cycle of stall.
- **Timeout.** A timed-out access stalls for 1+`DMEM_TIMEOUT` cycles. The DONE cycle is then a non-stalled drain.
- **Upstream stall interaction.** `EX_alu_busy` and `MEM_busy` can both be high in the same cycle. `MEM_busy` takes priority and nothing is captured.
- **Counter width.** The counter is `$clog2(DMEM_TIMEOUT+1)` bits wide and saturates; it never wraps.

## Configuration
- **Macro:** `MEM_MISALIGN_TRAP_EN`.
- **Defined.** A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, issues no request. It completes in 1 cycle with `MEM_WB_err`=1 and `we`=0.
- **Undefined.** Misaligned accesses are performed with `addr[1:0]` ignored: the half lane is taken from `addr[1]` and the word access is aligned. `err` is never set for alignment.

## Structure
- **Shared package.**
  - The `mem_ctrl` bit positions.
  - The size encodings (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`).
  - The state enum `mem_state_t`.
- **Sub-module `mem_align`.** Combinational, containing:
  - byte-enable generation;
  - store-data replication;
  - load-data extraction and extension;
  - misalignment detection.

## Test plan
- **Add passthrough.** Add with `alu_res`=0x1234 and `rd`=5 -> next cycle `MEM_WB_data`=0x1234, `rd`=5, `we`=1, no `dmem_req`.
- **Signed byte load.** Load byte, addr 0x103, `rdata`=0x80AA_BBCC, `ack` same cycle -> `be` not driven (load), `MEM_WB_data`=0xFFFF_FF80.
- **Unsigned half load.** Unsigned half load at addr 0x102, `rdata`=0x8001_0000 -> `MEM_WB_data`=0x0000_8001.
- **Byte store with waits.** Byte store of `din`=0x55 at addr 0x201, `ack` after 3 wait cycles -> `be`=0010, `wdata`=0x5555_5555, `addr`=0x200 held stable, `MEM_busy` high for 3 cycles.
- **Timeout.** No `ack` with `DMEM_TIMEOUT`=15 -> `MEM_busy` high for 16 cycles, then `MEM_WB_err`=1 and `we`=0, DONE for 1 cycle, next instruction proceeds.
- **Misalignment and reset.** Word load at 0x102 with `MEM_MISALIGN_TRAP_EN` -> no request, `err`=1. Separately, `rst` low during WAIT -> `dmem_req`=0 and `MEM_busy`=0 immediately.
